// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single external memory port between the instruction-fetch
// requester (imem) and the data-access requester (dmem). At most one transaction is in
// flight. The owner of that transaction receives the response pulse.
//
// Ports
//   clk_i, reset_ni           : clock and synchronous active-low reset
//   imem_req_*/imem_addr_i    : fetch request handshake; fetches are always word reads
//   imem_resp_*               : fetch response pulse and read data
//   dmem_req_*/dmem_*_i       : data request handshake with address, store enable, size, data
//   dmem_resp_*               : data response pulse (loads and stores) and read data
//   mem_req_*/mem_*_o         : downstream request handshake and latched request fields
//   mem_resp_*                : downstream response pulse and read data
//
// Configuration
//   MEM_PORT_ARBITER_ROUND_ROBIN_EN : when defined, simultaneous requests alternate between
//   requesters based on the last grant. When undefined, dmem has fixed priority over imem.

package definitions;
  typedef enum logic [1:0] {
    MemSizeByte = 2'd0,
    MemSizeHalf = 2'd1,
    MemSizeWord = 2'd2
  } mem_access_size_t;
endpackage

module mem_port_arbiter
  import definitions::*;
(
  input  logic             clk_i,
  input  logic             reset_ni,

  input  logic             imem_req_valid_i,
  output logic             imem_req_ready_o,
  input  logic [31:0]      imem_addr_i,
  output logic             imem_resp_valid_o,
  output logic [31:0]      imem_resp_data_o,

  input  logic             dmem_req_valid_i,
  output logic             dmem_req_ready_o,
  input  logic [31:0]      dmem_addr_i,
  input  logic             dmem_wr_enable_i,
  input  mem_access_size_t dmem_size_i,
  input  logic [31:0]      dmem_wr_data_i,
  output logic             dmem_resp_valid_o,
  output logic [31:0]      dmem_resp_data_o,

  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [31:0]      mem_addr_o,
  output logic             mem_wr_enable_o,
  output mem_access_size_t mem_size_o,
  output logic [31:0]      mem_wr_data_o,
  input  logic             mem_resp_valid_i,
  input  logic [31:0]      mem_resp_data_i
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  localparam logic OwnerImem = 1'b0;
  localparam logic OwnerDmem = 1'b1;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [31:0]      addr_q, addr_d;
  logic             wr_enable_q, wr_enable_d;
  mem_access_size_t size_q, size_d;
  logic [31:0]      wr_data_q, wr_data_d;

  logic grant_imem, grant_dmem, accept;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // On contention, the requester that was not granted last time wins.
  always_comb begin
    grant_dmem = dmem_req_valid_i && (!imem_req_valid_i || (last_grant_q == OwnerImem));
    grant_imem = imem_req_valid_i && !grant_dmem;
  end
`else
  always_comb begin
    grant_dmem = dmem_req_valid_i;
    grant_imem = imem_req_valid_i && !dmem_req_valid_i;
  end
`endif

  assign accept           = (state_q == StIdle) && (grant_imem || grant_dmem);
  assign imem_req_ready_o = (state_q == StIdle) && grant_imem;
  assign dmem_req_ready_o = (state_q == StIdle) && grant_dmem;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wr_enable_d = wr_enable_q;
    size_d      = size_q;
    wr_data_d   = wr_data_q;
    unique case (state_q)
      StIdle: begin
        // Any mem_resp_valid_i seen here is stray and is simply dropped.
        if (accept) begin
          state_d = StReq;
          if (grant_dmem) begin
            owner_d     = OwnerDmem;
            addr_d      = dmem_addr_i;
            wr_enable_d = dmem_wr_enable_i;
            size_d      = dmem_size_i;
            wr_data_d   = dmem_wr_data_i;
          end else begin
            owner_d     = OwnerImem;
            addr_d      = imem_addr_i;
            wr_enable_d = 1'b0;
            size_d      = MemSizeWord;
            wr_data_d   = 32'h0;
          end
        end
      end
      StReq: begin
        if (mem_req_ready_i) state_d = StResp;
      end
      StResp: begin
        if (mem_resp_valid_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      owner_q     <= OwnerImem;
      addr_q      <= 32'h0;
      wr_enable_q <= 1'b0;
      size_q      <= MemSizeByte;
      wr_data_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wr_enable_q <= wr_enable_d;
      size_q      <= size_d;
      wr_data_q   <= wr_data_d;
    end
  end

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = grant_dmem ? OwnerDmem : OwnerImem;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) last_grant_q <= OwnerDmem;
    else           last_grant_q <= last_grant_d;
  end
`endif

  assign mem_req_valid_o = (state_q == StReq);
  assign mem_addr_o      = addr_q;
  assign mem_wr_enable_o = wr_enable_q;
  assign mem_size_o      = size_q;
  assign mem_wr_data_o   = wr_data_q;

  // Response data is broadcast; only the valid pulse is steered to the owner.
  assign imem_resp_data_o  = mem_resp_data_i;
  assign dmem_resp_data_o  = mem_resp_data_i;
  assign imem_resp_valid_o = (state_q == StResp) && mem_resp_valid_i && (owner_q == OwnerImem);
  assign dmem_resp_valid_o = (state_q == StResp) && mem_resp_valid_i && (owner_q == OwnerDmem);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import definitions::*;

  logic             clk_i = 1'b0;
  logic             reset_ni;
  logic             imem_req_valid_i;
  logic             imem_req_ready_o;
  logic [31:0]      imem_addr_i;
  logic             imem_resp_valid_o;
  logic [31:0]      imem_resp_data_o;
  logic             dmem_req_valid_i;
  logic             dmem_req_ready_o;
  logic [31:0]      dmem_addr_i;
  logic             dmem_wr_enable_i;
  mem_access_size_t dmem_size_i;
  logic [31:0]      dmem_wr_data_i;
  logic             dmem_resp_valid_o;
  logic [31:0]      dmem_resp_data_o;
  logic             mem_req_valid_o;
  logic             mem_req_ready_i;
  logic [31:0]      mem_addr_o;
  logic             mem_wr_enable_o;
  mem_access_size_t mem_size_o;
  logic [31:0]      mem_wr_data_o;
  logic             mem_resp_valid_i;
  logic [31:0]      mem_resp_data_i;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i             (clk_i),
    .reset_ni          (reset_ni),
    .imem_req_valid_i  (imem_req_valid_i),
    .imem_req_ready_o  (imem_req_ready_o),
    .imem_addr_i       (imem_addr_i),
    .imem_resp_valid_o (imem_resp_valid_o),
    .imem_resp_data_o  (imem_resp_data_o),
    .dmem_req_valid_i  (dmem_req_valid_i),
    .dmem_req_ready_o  (dmem_req_ready_o),
    .dmem_addr_i       (dmem_addr_i),
    .dmem_wr_enable_i  (dmem_wr_enable_i),
    .dmem_size_i       (dmem_size_i),
    .dmem_wr_data_i    (dmem_wr_data_i),
    .dmem_resp_valid_o (dmem_resp_valid_o),
    .dmem_resp_data_o  (dmem_resp_data_o),
    .mem_req_valid_o   (mem_req_valid_o),
    .mem_req_ready_i   (mem_req_ready_i),
    .mem_addr_o        (mem_addr_o),
    .mem_wr_enable_o   (mem_wr_enable_o),
    .mem_size_o        (mem_size_o),
    .mem_wr_data_o     (mem_wr_data_o),
    .mem_resp_valid_i  (mem_resp_valid_i),
    .mem_resp_data_i   (mem_resp_data_i)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic exp_dmem;
    reset_ni         = 1'b0;
    imem_req_valid_i = 1'b0;
    imem_addr_i      = 32'h0;
    dmem_req_valid_i = 1'b0;
    dmem_addr_i      = 32'h0;
    dmem_wr_enable_i = 1'b0;
    dmem_size_i      = MemSizeByte;
    dmem_wr_data_i   = 32'h0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = 32'h0;
    step();
    step();
    reset_ni = 1'b1;
    #1;

    // Reset state.
    check("rst_mem_req_valid", 32'(mem_req_valid_o), 32'd0);
    check("rst_imem_ready", 32'(imem_req_ready_o), 32'd0);
    check("rst_dmem_ready", 32'(dmem_req_ready_o), 32'd0);
    check("rst_imem_resp", 32'(imem_resp_valid_o), 32'd0);
    check("rst_dmem_resp", 32'(dmem_resp_valid_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_size", 32'(mem_size_o), 32'd0);

    // Lone fetch.
    imem_req_valid_i = 1'b1;
    imem_addr_i      = 32'h100;
    #1;
    check("fetch_imem_ready_T", 32'(imem_req_ready_o), 32'd1);
    check("fetch_dmem_ready_T", 32'(dmem_req_ready_o), 32'd0);
    step();
    imem_req_valid_i = 1'b0;
    mem_req_ready_i  = 1'b1;
    #1;
    check("fetch_req_valid_T1", 32'(mem_req_valid_o), 32'd1);
    check("fetch_addr_T1", mem_addr_o, 32'h100);
    check("fetch_size_T1", 32'(mem_size_o), 32'(MemSizeWord));
    check("fetch_wr_en_T1", 32'(mem_wr_enable_o), 32'd0);
    check("fetch_dmem_resp_T1", 32'(dmem_resp_valid_o), 32'd0);
    step();
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 32'hDEADBEEF;
    #1;
    check("fetch_resp_valid_T2", 32'(imem_resp_valid_o), 32'd1);
    check("fetch_resp_data_T2", imem_resp_data_o, 32'hDEADBEEF);
    check("fetch_dmem_resp_T2", 32'(dmem_resp_valid_o), 32'd0);
    check("fetch_req_valid_T2", 32'(mem_req_valid_o), 32'd0);
    step();
    mem_resp_valid_i = 1'b0;
    #1;
    check("fetch_req_valid_T3", 32'(mem_req_valid_o), 32'd0);
    check("fetch_imem_resp_T3", 32'(imem_resp_valid_o), 32'd0);

    // Store with backpressure.
    dmem_req_valid_i = 1'b1;
    dmem_addr_i      = 32'h2000;
    dmem_wr_enable_i = 1'b1;
    dmem_size_i      = MemSizeByte;
    dmem_wr_data_i   = 32'hAB;
    #1;
    check("st_dmem_ready", 32'(dmem_req_ready_o), 32'd1);
    check("st_imem_ready", 32'(imem_req_ready_o), 32'd0);
    step();
    dmem_req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("st_hold_valid", 32'(mem_req_valid_o), 32'd1);
      check("st_hold_addr", mem_addr_o, 32'h2000);
      check("st_hold_wr_en", 32'(mem_wr_enable_o), 32'd1);
      check("st_hold_size", 32'(mem_size_o), 32'(MemSizeByte));
      check("st_hold_data", mem_wr_data_o, 32'hAB);
      check("st_hold_dmem_ready", 32'(dmem_req_ready_o), 32'd0);
      if (i == 3) mem_req_ready_i = 1'b1;
      step();
    end
    mem_req_ready_i = 1'b0;
    #1;
    check("st_resp_wait_valid", 32'(mem_req_valid_o), 32'd0);
    check("st_resp_wait_pulse", 32'(dmem_resp_valid_o), 32'd0);
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 32'h0;
    #1;
    check("st_resp_dmem", 32'(dmem_resp_valid_o), 32'd1);
    check("st_resp_imem", 32'(imem_resp_valid_o), 32'd0);
    step();
    mem_resp_valid_i = 1'b0;
    dmem_wr_enable_i = 1'b0;
    dmem_size_i      = MemSizeWord;

    // Contention: both requesters valid for four transactions.
    imem_req_valid_i = 1'b1;
    imem_addr_i      = 32'h300;
    dmem_req_valid_i = 1'b1;
    dmem_addr_i      = 32'h400;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
      exp_dmem = (k % 2) == 1;
`else
      exp_dmem = 1'b1;
`endif
      #1;
      check("cont_dmem_ready", 32'(dmem_req_ready_o), 32'(exp_dmem));
      check("cont_imem_ready", 32'(imem_req_ready_o), 32'(!exp_dmem));
      step();
      mem_req_ready_i = 1'b1;
      #1;
      check("cont_addr", mem_addr_o, exp_dmem ? 32'h400 : 32'h300);
      check("cont_req_imem_ready", 32'(imem_req_ready_o), 32'd0);
      step();
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = 32'h1000 + 32'(k);
      #1;
      check("cont_resp_dmem", 32'(dmem_resp_valid_o), 32'(exp_dmem));
      check("cont_resp_imem", 32'(imem_resp_valid_o), 32'(!exp_dmem));
      check("cont_resp_data", dmem_resp_data_o, 32'h1000 + 32'(k));
      step();
      mem_resp_valid_i = 1'b0;
    end
    imem_req_valid_i = 1'b0;
    dmem_req_valid_i = 1'b0;

    // Reset mid-RESP, then stray response.
    imem_req_valid_i = 1'b1;
    imem_addr_i      = 32'h500;
    step();
    imem_req_valid_i = 1'b0;
    mem_req_ready_i  = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    reset_ni        = 1'b0;
    step();
    reset_ni         = 1'b1;
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 32'h5A5A5A5A;
    #1;
    check("rr_stray_imem_resp", 32'(imem_resp_valid_o), 32'd0);
    check("rr_stray_dmem_resp", 32'(dmem_resp_valid_o), 32'd0);
    check("rr_req_valid", 32'(mem_req_valid_o), 32'd0);
    check("rr_addr_cleared", mem_addr_o, 32'h0);
    step();
    mem_resp_valid_i = 1'b0;
    imem_req_valid_i = 1'b1;
    imem_addr_i      = 32'h600;
    #1;
    check("rr_new_fetch_ready", 32'(imem_req_ready_o), 32'd1);
    step();
    imem_req_valid_i = 1'b0;
    #1;
    check("rr_new_fetch_valid", 32'(mem_req_valid_o), 32'd1);
    check("rr_new_fetch_addr", mem_addr_o, 32'h600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
